// File: rtl/uart_frame_loader.sv
// uart_frame_loader: frames a UART byte stream (header, 16-bit payload words, checksum)
// into sequential SRAM word writes over a req/ack port, reporting completion or error.
module uart_frame_loader #(
  parameter int         CLK_FRE        = 50,
  parameter int         ADDR_WIDTH     = 18,
  parameter int         FRAME_WORDS    = 76800,
  parameter logic [7:0] HDR0           = 8'hA5,
  parameter logic [7:0] HDR1           = 8'h5A,
  parameter int         TIMEOUT_CYCLES = CLK_FRE * 10000
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_wr_req,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [15:0]           o_wr_data,
  input  logic                  i_wr_ack,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  typedef enum logic [2:0] {IDLE, HDR, LO, HI, WRITE, CHK} state_t;
  state_t                state_q, state_d;
  logic                  hold_full_q, hold_full_d;
  logic [7:0]            hold_data_q, hold_data_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            sum_q, sum_d, lo_q, lo_d;
  logic [15:0]           data_q, data_d;
  logic                  req_q, req_d, abort_q, abort_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic                  consume, ovf, tmo_hit, drain;
  always_comb begin
    consume     = i_en && hold_full_q && state_q != WRITE;
    ovf         = i_en && i_rx_done && hold_full_q && !consume && !abort_q;
    tmo_hit     = state_q != IDLE && state_q != WRITE && !consume && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    drain       = req_q && !i_wr_ack;
    state_d     = state_q;
    hold_full_d = hold_full_q && !consume;
    hold_data_d = hold_data_q;
    tmo_d       = (state_q == IDLE || state_q == WRITE || consume) ? '0 : tmo_q + 1'b1;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    lo_d        = lo_q;
    data_d      = data_q;
    req_d       = req_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    if (i_en && i_rx_done) begin
      hold_full_d = 1'b1;
      hold_data_d = i_rx_data;
    end
    if (!i_en || ovf) hold_full_d = 1'b0;
    unique case (state_q)
      IDLE: if (consume && hold_data_q == HDR0) state_d = HDR;
      HDR: if (consume) begin
        state_d = hold_data_q == HDR1 ? LO : hold_data_q == HDR0 ? HDR : IDLE;
        if (hold_data_q == HDR1) begin
          addr_d = i_base_addr;
          cnt_d  = '0;
          sum_d  = '0;
        end
      end
      LO: if (consume) begin
        lo_d    = hold_data_q;
        sum_d   = sum_q + hold_data_q;
        state_d = HI;
      end
      HI: if (consume) begin
        data_d  = {hold_data_q, lo_q};
        sum_d   = sum_q + hold_data_q;
        req_d   = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (i_wr_ack) begin
        req_d   = 1'b0;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        abort_d = 1'b0;
        state_d = abort_q ? IDLE : cnt_q == CW'(FRAME_WORDS - 1) ? CHK : LO;
      end
      CHK: if (consume) begin
        done_d  = hold_data_q == sum_q;
        err_d   = hold_data_q != sum_q;
        code_d  = hold_data_q == sum_q ? 2'b00 : 2'b10;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // errors and disable still let an outstanding write finish before IDLE
    if (!abort_q && (ovf || tmo_hit)) begin
      err_d   = 1'b1;
      code_d  = ovf ? 2'b11 : 2'b01;
      abort_d = drain;
      state_d = drain ? WRITE : IDLE;
    end
    if (!i_en) begin
      abort_d = drain;
      state_d = drain ? WRITE : IDLE;
    end
  end
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      lo_q        <= '0;
      data_q      <= '0;
      req_q       <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      lo_q        <= lo_d;
      data_q      <= data_d;
      req_q       <= req_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end
  assign o_wr_req     = req_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = data_q;
  assign o_busy       = state_q != IDLE;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_err_code   = code_q;
endmodule
